// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single 32xDW synchronous RAM.
// One request is accepted at a time; reads return data with a per-port rvalid pulse.
module ram_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_cen,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    state_dbg
);

  // Handshake: a requester raises req with wr/addr/wdata stable and holds them
  // until its ack pulse; req is only sampled in IDLE, so it must drop on ack or
  // it is taken as a fresh transaction the next time the FSM returns to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   is_read;

  logic          any_req;
  logic          grant_w;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // On a tie the port that did not win last time is served, so a loser is next.
  always_comb begin
    any_req   = req0 | req1;
    grant_w   = 1'b0;
    if (req0 && req1) begin
      grant_w = ~last_grant;
    end else if (req1) begin
      grant_w = 1'b1;
    end
    sel_wr    = grant_w ? wr1    : wr0;
    sel_addr  = grant_w ? addr1  : addr0;
    sel_wdata = grant_w ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      is_read    <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata      <= '0;
      ram_cen    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      ram_cen <= 1'b0;
      ram_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            ram_cen    <= 1'b1;
            ram_wen    <= sel_wr;
            ram_addr   <= sel_addr;
            ram_din    <= sel_wdata;
            ack0       <= ~grant_w;
            ack1       <= grant_w;
            owner      <= grant_w;
            last_grant <= grant_w;
            is_read    <= ~sel_wr;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // RAM performs the op at this edge; address/data are left as they were.
          state <= is_read ? CAPTURE : IDLE;
        end
        CAPTURE: begin
          rdata   <= ram_dout;
          rvalid0 <= ~owner;
          rvalid1 <= owner;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // The RAM must never see two ops back to back.
  a_cen_single: assert property (@(posedge clk) disable iff (reset) ram_cen |=> !ram_cen);
  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
  a_rv_onehot:  assert property (@(posedge clk) disable iff (reset) !(rvalid0 && rvalid1));

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural 32x32 RAM, directed vector table plus
// hand-written sequences for tie-break, fairness, reset and back-to-back reads.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, wr0, req1, wr1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1, busy;
  logic [31:0] rdata;
  logic        ram_cen, ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [1:0]  state_dbg;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int last_ack_cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model[32];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .state_dbg(state_dbg)
  );

  // Behavioural RAM: registered read, dout clears when not enabled.
  logic [31:0] mem[32];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 7) ? 32'h0 : 32'h11 * i;
      mem_init <= 1'b1;
      ram_dout <= '0;
    end else if (ram_cen) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      ram_dout <= ram_wen ? 32'h0 : mem[ram_addr];
    end else begin
      ram_dout <= '0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit p, input bit wr, input logic [4:0] a, input logic [31:0] d);
    if (p) begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d; end
  endtask

  task automatic drop(input bit p);
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // Waits (bounded) for the port's ack; returns 1 if seen, with cycles waited.
  task automatic wait_ack(input bit p, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (n < 8 && !got) begin
      @(negedge clk);
      n++;
      got = p ? ack1 : ack0;
    end
    if (!got) begin
      tests++;
      failed++;
      $display("FAIL ack_timeout: port %0d got no ack, required ack within 8 cycles", p);
    end
  endtask

  // Full transaction from an IDLE negedge; returns at the negedge after the
  // last output of the transaction so the next request follows immediately.
  task automatic run_txn(input bit p, input bit wr, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
    bit got;
    int n;
    drive(p, wr, a, d);
    wait_ack(p, got, n);
    if (!got) begin drop(p); return; end
    last_ack_cyc = cyc;
    check("ack_latency", n, 1);
    check("ack_other", p ? ack0 : ack1, 0);
    check("cen_on", ram_cen, 1);
    check("wen", ram_wen, wr);
    check("ram_addr", ram_addr, a);
    if (wr) check("ram_din", ram_din, d);
    check("busy_issue", busy, 1);
    check("rvalid_clear", {rvalid0, rvalid1}, 0);
    drop(p);
    @(negedge clk);
    check("ack_pulse", {ack0, ack1}, 0);
    check("cen_off", ram_cen, 0);
    check("busy_after_issue", busy, !wr);
    if (wr) begin
      model[a] = d;
      return;
    end
    exp_q.push_back(exp);
    @(negedge clk);
    check("rvalid_own", p ? rvalid1 : rvalid0, 1);
    check("rvalid_other", p ? rvalid0 : rvalid1, 0);
    check("rdata", rdata, exp_q.pop_front());
    check("busy_idle", busy, 0);
  endtask

  typedef struct {
    bit          port;
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    int n;
    int rv_seen;
    int grants[8];
    int g, k0, k1;
    bit rearm0, rearm1;

    for (int i = 0; i < 32; i++) model[i] = (i == 7) ? 32'h0 : 32'h11 * i;
    vecs[0] = '{0, 1, 5'd5,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 0, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 0, 5'd3,  32'h0,        32'h00000033};
    vecs[3] = '{1, 1, 5'd31, 32'hA5A5A5A5, 32'h0};
    vecs[4] = '{0, 0, 5'd31, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{1, 0, 5'd0,  32'h0,        32'h00000000};
    vecs[6] = '{0, 1, 5'd0,  32'hFFFFFFFF, 32'h0};
    vecs[7] = '{1, 0, 5'd0,  32'h0,        32'hFFFFFFFF};
    vecs[8] = '{0, 0, 5'd7,  32'h0,        32'h00000000};
    vecs[9] = '{1, 0, 5'd12, 32'h0,        32'h000000CC};

    reset = 1'b1;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_outputs", {ack0, ack1, rvalid0, rvalid1, busy, ram_cen, ram_wen}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr_din", {27'd0, ram_addr} | ram_din, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_cen", ram_cen, 0);
    check("idle_busy", busy, 0);

    // Simultaneous requests straight out of reset: port 0 wins the first tie
    drive(0, 1, 5'd10, 32'hCAFE0000);
    drive(1, 0, 5'd3, 32'h0);
    @(negedge clk);
    check("tie_ack0", {ack0, ack1}, 2'b10);
    drop(0);
    @(negedge clk);
    check("tie_gap", {ack0, ack1}, 2'b00);
    model[10] = 32'hCAFE0000;
    @(negedge clk);
    check("tie_ack1", {ack0, ack1}, 2'b01);
    check("tie_p1_addr", ram_addr, 5'd3);
    check("tie_p1_wen", ram_wen, 0);
    drop(1);
    @(negedge clk);
    @(negedge clk);
    check("tie_rvalid", {rvalid0, rvalid1}, 2'b01);
    check("tie_rdata", rdata, 32'h00000033);
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    @(negedge clk);

    // Fairness: both ports keep writing; grants must alternate starting at port 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    k0 = 0; k1 = 0; g = 0; rearm0 = 0; rearm1 = 0;
    drive(0, 1, 5'd16, 32'hF0000000);
    drive(1, 1, 5'd17, 32'hE0000000);
    for (int c = 0; c < 60 && g < 8; c++) begin
      @(negedge clk);
      if (rearm0) begin drive(0, 1, 5'd16, 32'hF0000000 + k0); rearm0 = 0; end
      if (rearm1) begin drive(1, 1, 5'd17, 32'hE0000000 + k1); rearm1 = 0; end
      check("fair_not_both", {31'd0, ack0 & ack1}, 0);
      if (ack0) begin
        grants[g] = 0; g++;
        model[16] = wdata0; k0++;
        drop(0); rearm0 = 1;
      end else if (ack1) begin
        grants[g] = 1; g++;
        model[17] = wdata1; k1++;
        drop(1); rearm1 = 1;
      end
    end
    drop(0); drop(1);
    check("fair_count", g, 8);
    for (int i = 0; i < g; i++) check($sformatf("fair_grant%0d", i), grants[i], i % 2);
    repeat (3) @(negedge clk);

    // Reset during ISSUE: write must not happen, outputs clear immediately
    drive(1, 1, 5'd7, 32'h12345678);
    wait_ack(1, got, n);
    reset = 1'b1;
    #1;
    check("rst_issue_cen", {ram_cen, ram_wen}, 0);
    check("rst_issue_ack", {ack0, ack1}, 0);
    check("rst_issue_busy", busy, 0);
    check("rst_issue_addr", ram_addr, 0);
    check("rst_issue_din", ram_din, 0);
    drop(1);
    @(negedge clk);
    reset = 1'b0;
    rv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      rv_seen += int'(rvalid0) + int'(rvalid1);
    end
    check("rst_issue_no_rvalid", rv_seen, 0);
    run_txn(1, 0, 5'd7, 32'h0, 32'h00000000);

    // Reset during CAPTURE: read is discarded
    drive(0, 0, 5'd3, 32'h0);
    wait_ack(0, got, n);
    drop(0);
    @(negedge clk);
    check("cap_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_cap_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      rv_seen += int'(rvalid0) + int'(rvalid1);
    end
    check("rst_cap_no_rvalid", rv_seen, 0);

    // Back-to-back reads over the whole address space, one every 3 cycles
    for (int i = 0; i < 32; i++) begin
      int prev;
      prev = last_ack_cyc;
      run_txn(0, 0, i[4:0], 32'h0, model[i]);
      if (i > 0) check($sformatf("b2b_spacing%0d", i), last_ack_cyc - prev, 3);
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
